// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU command queue and its users.
//   - alu_op_t     : 3-bit ALU opcode type
//   - OP_AND/OP_OR/OP_ADD/OP_SUB : the opcodes the ALU implements
//   - op_is_legal  : true for an opcode the ALU implements
//   - ALU_WIDTH    : default operand width
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_AND = 3'b000;
  localparam alu_op_t OP_OR  = 3'b001;
  localparam alu_op_t OP_ADD = 3'b010;
  localparam alu_op_t OP_SUB = 3'b110;

  function automatic logic op_is_legal(input alu_op_t op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// alu_cmd_queue_if: command bus into and out of the ALU command queue.
//   in_valid/in_ready/in_a/in_b/in_op     : producer (decode) side
//   out_valid/out_ready/out_a/out_b/out_op : consumer (ALU) side
// Modports: master = producer + consumer (the environment), slave = the queue.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// valid never depends on ready; while valid && !ready the sender holds its
// payload stable until the transfer happens.
interface alu_cmd_queue_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  alu_op_t          in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  alu_op_t          out_op;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op
  );
endinterface

// File: rtl/alu_cmd_fifo_ctl.sv
// alu_cmd_fifo_ctl: pointer/occupancy control for the ALU command queue.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_push_req    : producer wants to enqueue (already opcode-qualified)
//   i_pop_req     : consumer ready to take the head
//   o_in_ready    : registered "not full"; 0 while in reset
//   o_out_valid   : queue is non-empty
//   o_push/o_pop  : qualified enqueue / dequeue this cycle
//   o_wr_ptr/o_rd_ptr : storage indices, wrap modulo DEPTH
//   o_count       : occupied entries
module alu_cmd_fifo_ctl #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push_req,
  input  logic          i_pop_req,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic          o_push,
  output logic          o_pop,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;

  assign w_out_valid = (r_count != '0);
  assign w_push      = i_push_req && r_in_ready;
  assign w_pop       = i_pop_req && w_out_valid;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // in_ready is registered from the next count, so a pop while full only
  // re-opens the input on the following cycle and out_ready has no
  // combinational path to in_ready. It also stays 0 until the first edge
  // after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < FULL_CNT);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_push      = w_push;
  assign o_pop       = w_pop;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_count     = r_count;
endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: issue queue in front of the 32-bit ALU. Buffers (a, b, op)
// commands and presents the oldest one to the ALU under valid/ready.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : producer in_* and consumer out_* handshakes
//   count        : occupied entries
//   err_illegal  : one-cycle pulse per dropped illegal opcode
//   illegal_cnt  : saturating (255) count of dropped commands
// Build option: define ALU_CMD_OP_CHECK_EN to drop commands whose opcode the
// ALU does not implement (handshaked but not enqueued). Without it every
// handshaked command is enqueued and err_illegal/illegal_cnt read 0.
// DEPTH must be a power of two, at least 2 (pointers wrap by overflow).
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int EW = 2 * WIDTH + 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_cmd_queue_if.slave bus,
  output logic [CW-1:0] count,
  output logic          err_illegal,
  output logic [7:0]    illegal_cnt
);
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic [EW-1:0] w_head;

  // Entry layout: {a, b, op}
  logic [EW-1:0] r_mem [DEPTH];

`ifdef ALU_CMD_OP_CHECK_EN
  logic       w_legal;
  logic       w_drop;
  logic       r_err;
  logic [7:0] r_illegal_cnt;

  assign w_legal    = op_is_legal(bus.in_op);
  // An illegal command still completes its handshake; it just never lands.
  assign w_drop     = bus.in_valid && w_in_ready && !w_legal;
  assign w_push_req = bus.in_valid && w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err         <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_illegal_cnt != 8'hFF)) r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

  assign err_illegal = r_err;
  assign illegal_cnt = r_illegal_cnt;
`else
  assign w_push_req  = bus.in_valid;
  assign err_illegal = 1'b0;
  assign illegal_cnt = '0;
`endif

  alu_cmd_fifo_ctl #(.DEPTH(DEPTH)) u_ctl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push_req  (w_push_req),
    .i_pop_req   (bus.out_ready),
    .o_in_ready  (w_in_ready),
    .o_out_valid (w_out_valid),
    .o_push      (w_push),
    .o_pop       (w_pop),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (count)
  );

  // Storage holds no reset; stale contents are hidden by the output gating.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
  end

  assign w_head = r_mem[w_rd_ptr];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_a     = w_out_valid ? w_head[EW-1 -: WIDTH] : '0;
  assign bus.out_b     = w_out_valid ? w_head[WIDTH+2 -: WIDTH] : '0;
  assign bus.out_op    = w_out_valid ? w_head[2:0] : '0;

  // Pop is consumed only by the pointer logic inside the controller.
  logic w_unused;
  assign w_unused = w_pop;
endmodule

// File: tb/tb_alu_cmd_queue.sv
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int D    = 4;
  localparam int CW   = $clog2(D) + 1;
  localparam int CMDW = 2 * W + 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_queue_if #(.WIDTH(W)) bus();
  logic [CW-1:0] count;
  logic          err_illegal;
  logic [7:0]    illegal_cnt;

  alu_cmd_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .count       (count),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [CMDW-1:0] exp_q[$];   // commands expected in the queue, oldest first
  bit              m_ready;
  bit              m_err;
  int              m_cnt;
  int              n_pass;
  int              n_total;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110);
  endfunction

  function automatic logic [W-1:0] alu_z(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic check_all();
    logic [CMDW-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("count",       count,         exp_q.size());
    chk("in_ready",    bus.in_ready,  m_ready);
    chk("out_valid",   bus.out_valid, exp_q.size() != 0);
    chk("out_a",       bus.out_a,     h[CMDW-1 -: W]);
    chk("out_b",       bus.out_b,     h[W+2 -: W]);
    chk("out_op",      bus.out_op,    h[2:0]);
    chk("err_illegal", err_illegal,   m_err);
    chk("illegal_cnt", illegal_cnt,   m_cnt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic ordy);
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.out_ready = ordy;
  endtask

  // One clock: sample the handshake, let the edge happen, advance the model,
  // then compare every output 1 time unit after the edge.
  task automatic step();
    bit              hs, pop, lg;
    logic [CMDW-1:0] cmd;
    hs  = bus.in_valid && m_ready;
    pop = bus.out_ready && (exp_q.size() != 0);
    cmd = {bus.in_a, bus.in_b, bus.in_op};
    if (pop) chk("pop_order", {bus.out_a, bus.out_b, bus.out_op}, exp_q[0]);
`ifdef ALU_CMD_OP_CHECK_EN
    lg = model_legal(bus.in_op);
`else
    lg = 1'b1;
`endif
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (hs && lg) exp_q.push_back(cmd);
`ifdef ALU_CMD_OP_CHECK_EN
    m_err = hs && !lg;
    if (m_err && m_cnt < 255) m_cnt++;
`endif
    m_ready = (exp_q.size() < D);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 3'b000, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 3'b000, 1'b1);
    for (int i = 0; i < D + 1; i++) step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          iv;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          ordy;
    logic          ev;   // expected out_valid after the edge
    logic [W-1:0]  ea;   // expected out_a after the edge
    logic [CW-1:0] ec;   // expected count after the edge
    logic          er;   // expected in_ready after the edge
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [2:0] ops[4];
    int pushed, popped, guard;
    bit will_push, will_pop, tog;

    n_pass = 0;
    n_total = 0;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;

    //           iv  a   b   op      ordy ev  ea  ec  er
    tbl[0]  = '{1'b1, 5, 3, 3'b010, 1'b0, 1'b1, 5, 1, 1'b1};
    tbl[1]  = '{1'b1, 6, 4, 3'b000, 1'b0, 1'b1, 5, 2, 1'b1};
    tbl[2]  = '{1'b1, 7, 1, 3'b001, 1'b0, 1'b1, 5, 3, 1'b1};
    tbl[3]  = '{1'b1, 8, 2, 3'b110, 1'b0, 1'b1, 5, 4, 1'b0};
    tbl[4]  = '{1'b1, 9, 9, 3'b010, 1'b0, 1'b1, 5, 4, 1'b0};  // held off while full
    tbl[5]  = '{1'b1, 9, 9, 3'b010, 1'b1, 1'b1, 6, 3, 1'b1};  // pop at full: no push yet
    tbl[6]  = '{1'b1, 9, 9, 3'b010, 1'b0, 1'b1, 6, 4, 1'b0};  // accepted next cycle
    tbl[7]  = '{1'b0, 0, 0, 3'b000, 1'b1, 1'b1, 7, 3, 1'b1};
    tbl[8]  = '{1'b0, 0, 0, 3'b000, 1'b1, 1'b1, 8, 2, 1'b1};
    tbl[9]  = '{1'b0, 0, 0, 3'b000, 1'b1, 1'b1, 9, 1, 1'b1};
    tbl[10] = '{1'b0, 0, 0, 3'b000, 1'b1, 1'b0, 0, 0, 1'b1};
    tbl[11] = '{1'b0, 0, 0, 3'b000, 1'b1, 1'b0, 0, 0, 1'b1};  // pop while empty ignored

    // reset state
    #2;
    do_reset();
    step();   // first edge after release: in_ready comes up

    // single push, fill, hold-off, drain
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].ordy);
      step();
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_a", i),     bus.out_a,     tbl[i].ea);
      chk($sformatf("tbl%0d_count", i), count,         tbl[i].ec);
      chk($sformatf("tbl%0d_ready", i), bus.in_ready,  tbl[i].er);
      if (i == 0) chk("alu_z_5plus3", alu_z(bus.out_a, bus.out_b, bus.out_op), 32'd8);
    end

    // order and wrap: 10 commands, out_ready toggling
    pushed = 0; popped = 0; guard = 0; tog = 1'b0;
    while ((pushed < 10 || popped < 10) && guard < 200) begin
      drive(pushed < 10, pushed, 2 * pushed, ops[pushed % 4], tog);
      will_push = bus.in_valid && m_ready;
      will_pop  = bus.out_ready && (exp_q.size() != 0);
      step();
      if (will_push) pushed++;
      if (will_pop)  popped++;
      tog = ~tog;
      guard++;
    end
    chk("wrap_done", guard < 200, 1'b1);
    chk("wrap_empty", count, 0);

    // simultaneous push and pop at count 2
    drive(1'b1, 32'h11, 32'h1, OP_ADD, 1'b0);
    step();
    drive(1'b1, 32'h22, 32'h2, OP_OR, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h100 + k, 32'h200 + k, ops[k % 4], 1'b1);
      step();
      chk("simul_count", count, 2);
    end
    drain();

`ifdef ALU_CMD_OP_CHECK_EN
    drive(1'b1, 32'hA, 32'hB, OP_AND, 1'b0);
    step();
    drive(1'b1, 32'hC, 32'hD, 3'b011, 1'b0);
    step();
    chk("illegal_pulse", err_illegal, 1'b1);
    chk("illegal_count_unchanged", count, 1);
    drive(1'b1, 32'hE, 32'hF, OP_SUB, 1'b0);
    step();
    chk("illegal_pulse_end", err_illegal, 1'b0);
    chk("illegal_cnt_one", illegal_cnt, 8'd1);
    chk("illegal_two_queued", count, 2);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, k, k, 3'b011, 1'b1);
      step();
    end
    chk("illegal_cnt_sat", illegal_cnt, 8'd255);
    drain();
`else
    drive(1'b1, 32'h33, 32'h44, 3'b011, 1'b0);
    step();
    chk("unfiltered_op_head", bus.out_op, 3'b011);
    drain();
`endif

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0);
      step();
    end

    // reset mid-operation with count 3 and a push in flight
    drain();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h700 + k, 32'h1, OP_ADD, 1'b0);
      step();
    end
    chk("pre_reset_count", count, 3);
    drive(1'b1, 32'hAA, 32'hBB, OP_SUB, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h55, 32'h66, OP_ADD, 1'b0);
    step();   // not accepted yet: in_ready rises on this edge
    step();   // accepted
    drive(1'b0, '0, '0, 3'b000, 1'b0);
    step();
    chk("post_rst_alone", count, 1);
    chk("post_rst_head", bus.out_a, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
